// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-side responder of the MESI
// snooping system. Imported by mem_ctrl and mem_resp_fifo.
//   bus_msg_t    : snooped bus message {valid, cmd, source, addr}
//   xbar_msg_t   : crossbar message {valid, dest, addr, data, writeback}
//   dir_entry_t  : per-line directory state {owned, owner, sharers, wb_pend}
//   resp_entry_t : pending response {dest, addr, age}
package mem_ctrl_pkg;

    localparam int NUM_CPUS = 4;
    localparam int XLEN     = 6;
    localparam int DLEN     = 8;
    localparam int CPU_W    = $clog2(NUM_CPUS);

    localparam int MEM_LATENCY = 4;
    localparam int RESP_DEPTH  = 4;

    // Age field is sized for the largest latency the block is meant to be
    // configured with; MEM_LATENCY must not exceed MAX_LATENCY.
    localparam int MAX_LATENCY = 15;
    localparam int AGE_W       = $clog2(MAX_LATENCY + 1);

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_GETS = 2'd1,
        BUS_GETM = 2'd2,
        BUS_PUTM = 2'd3
    } bus_cmd_t;

    typedef struct packed {
        logic             valid;
        bus_cmd_t         cmd;
        logic [CPU_W-1:0] source;
        logic [XLEN-1:0]  addr;
    } bus_msg_t;

    typedef struct packed {
        logic             valid;
        logic [CPU_W-1:0] dest;
        logic [XLEN-1:0]  addr;
        logic [DLEN-1:0]  data;
        logic             writeback;
    } xbar_msg_t;

    typedef struct packed {
        logic                owned;
        logic [CPU_W-1:0]    owner;
        logic [NUM_CPUS-1:0] sharers;
        logic                wb_pend;
    } dir_entry_t;

    typedef struct packed {
        logic [CPU_W-1:0] dest;
        logic [XLEN-1:0]  addr;
        logic [AGE_W-1:0] age;
    } resp_entry_t;

    // One-hot sharer mask for a CPU index.
    function automatic logic [NUM_CPUS-1:0] cpu_bit(input logic [CPU_W-1:0] cpu);
        logic [NUM_CPUS-1:0] mask;
        mask      = '0;
        mask[cpu] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// In-order pending-response queue with a per-entry age counter.
//   clk, rst      : clock, asynchronous active-high reset
//   push          : enqueue {push_dest, push_addr}
//   pop           : remove head (only honoured while head_eligible)
//   head_ok       : external eligibility (head line has no writeback pending)
//   full, empty   : occupancy flags
//   head_eligible : head has aged MEM_LATENCY cycles and head_ok is set
//   head          : current head entry
module mem_resp_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH   = RESP_DEPTH,
    parameter int LATENCY = MEM_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [CPU_W-1:0] push_dest,
    input  logic [XLEN-1:0]  push_addr,
    input  logic             pop,
    input  logic             head_ok,
    output logic             full,
    output logic             empty,
    output logic             head_eligible,
    output resp_entry_t      head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY);

    resp_entry_t      entry_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full          = (count_reg == CNT_W'(DEPTH));
    assign empty         = (count_reg == '0);
    assign head          = entry_reg[rd_ptr_reg];
    assign head_eligible = !empty && (head.age == AGE_MAX) && head_ok;
    assign do_pop        = pop && head_eligible;
    // A slot freed by a simultaneous pop may be refilled the same cycle.
    assign do_push       = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_reg[i].age != AGE_MAX) begin
                    entry_reg[i].age <= entry_reg[i].age + AGE_W'(1);
                end
            end
            // The accept cycle itself counts as age 0, so the stored value
            // starts at 1; that makes the response issue exactly LATENCY
            // cycles after the bus accept.
            if (do_push) begin
                entry_reg[wr_ptr_reg] <= '{dest: push_dest, addr: push_addr, age: AGE_W'(1)};
                wr_ptr_reg            <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory-side responder on the MESI snooping bus. Snoops granted bus
// messages, keeps a per-line directory (owner / sharers / writeback pending),
// answers requests that no cache can satisfy and absorbs dirty writebacks.
//   clk, rst   : clock, asynchronous active-high reset
//   bus_in     : snooped bus message, consumed when valid && bus_ready
//   bus_ready  : low while the response queue is full
//   wb_in      : crossbar message to memory; only writebacks are acted on
//   resp_out   : data response towards a CPU (writeback always 0)
//   resp_ready : crossbar accepts resp_out this cycle
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = mem_ctrl_pkg::MEM_LATENCY,
    parameter int RESP_DEPTH  = mem_ctrl_pkg::RESP_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  bus_msg_t  bus_in,
    output logic      bus_ready,
    input  xbar_msg_t wb_in,
    output xbar_msg_t resp_out,
    input  logic      resp_ready
);

    localparam int MEM_WORDS = 2 ** XLEN;

    logic [DLEN-1:0] mem_reg [MEM_WORDS];
    dir_entry_t      dir_reg [MEM_WORDS];

    dir_entry_t  dir_cur;
    dir_entry_t  dir_next;
    logic        need_resp;
    logic        wb_set;
    logic        accept;
    logic        wb_hit;
    logic        fifo_full;
    logic        fifo_empty;
    logic        head_eligible;
    resp_entry_t head;
    logic        unused_bits;

    assign accept  = bus_in.valid && bus_ready && (bus_in.cmd != BUS_IDLE);
    assign wb_hit  = wb_in.valid && wb_in.writeback;
    assign dir_cur = dir_reg[bus_in.addr];
    assign bus_ready = !fifo_full;
    assign unused_bits = ^{wb_in.dest, head.age, fifo_empty};

    // Directory decode for the snooped message.
    always_comb begin
        dir_next  = dir_cur;
        need_resp = 1'b0;
        wb_set    = 1'b0;
        case (bus_in.cmd)
            BUS_GETS: begin
                if (!dir_cur.owned) begin
                    need_resp = 1'b1;
                    if (dir_cur.sharers == '0) begin
                        dir_next.owned = 1'b1;
                        dir_next.owner = bus_in.source;
                    end
                    dir_next.sharers = dir_cur.sharers | cpu_bit(bus_in.source);
                end else begin
                    // Owner supplies the data and sends memory a copy.
                    dir_next.owned   = 1'b0;
                    wb_set           = 1'b1;
                    dir_next.sharers = dir_cur.sharers | cpu_bit(bus_in.source)
                                       | cpu_bit(dir_cur.owner);
                end
            end
            BUS_GETM: begin
                need_resp        = !dir_cur.owned;
                dir_next.owned   = 1'b1;
                dir_next.owner   = bus_in.source;
                dir_next.sharers = cpu_bit(bus_in.source);
            end
            BUS_PUTM: begin
                // Stale or raced PutMs leave the directory untouched.
                if (dir_cur.owned && (dir_cur.owner == bus_in.source)) begin
                    dir_next.owned   = 1'b0;
                    dir_next.sharers = dir_cur.sharers & ~cpu_bit(bus_in.source);
                    wb_set           = 1'b1;
                end
            end
            default: ;
        endcase
        // A same-line writeback clears wb_pend unless this message sets it again.
        if (wb_set) begin
            dir_next.wb_pend = 1'b1;
        end else if (wb_hit && (wb_in.addr == bus_in.addr)) begin
            dir_next.wb_pend = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_reg[i] <= DLEN'(i);
                dir_reg[i] <= '0;
            end
        end else begin
            if (wb_hit) begin
                mem_reg[wb_in.addr]         <= wb_in.data;
                dir_reg[wb_in.addr].wb_pend <= 1'b0;
            end
            // Issued after the writeback clear so a same-line update wins.
            if (accept) begin
                dir_reg[bus_in.addr] <= dir_next;
            end
        end
    end

    mem_resp_fifo #(
        .DEPTH   (RESP_DEPTH),
        .LATENCY (MEM_LATENCY)
    ) u_resp_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (accept && need_resp),
        .push_dest     (bus_in.source),
        .push_addr     (bus_in.addr),
        .pop           (resp_ready),
        .head_ok       (!dir_reg[head.addr].wb_pend),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .head_eligible (head_eligible),
        .head          (head)
    );

    // Response data is read at issue time; a writeback to the same line in
    // that cycle is forwarded so the response never carries stale data.
    always_comb begin
        resp_out = '0;
        if (head_eligible) begin
            resp_out.valid = 1'b1;
            resp_out.dest  = head.dest;
            resp_out.addr  = head.addr;
            resp_out.data  = (wb_hit && (wb_in.addr == head.addr)) ? wb_in.data
                                                                   : mem_reg[head.addr];
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios followed by random
// traffic, all compared cycle by cycle against a queue/array reference model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam int NADDR = 2 ** XLEN;

    logic      clk = 1'b0;
    logic      rst;
    bus_msg_t  bus_in;
    logic      bus_ready;
    xbar_msg_t wb_in;
    xbar_msg_t resp_out;
    logic      resp_ready;

    always #5 clk = ~clk;

    mem_ctrl #(.MEM_LATENCY(LAT), .RESP_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .bus_ready  (bus_ready),
        .wb_in      (wb_in),
        .resp_out   (resp_out),
        .resp_ready (resp_ready)
    );

    // Reference model: plain arrays for memory and directory, a queue of
    // outstanding responses stamped with their accept cycle.
    typedef struct {int dest; int addr; int t;} exp_resp_t;
    int        m_mem     [NADDR];
    bit        m_owned   [NADDR];
    int        m_owner   [NADDR];
    int        m_sharers [NADDR];
    bit        m_wbp     [NADDR];
    exp_resp_t m_q [$];
    int        cyc;

    int n_pass  = 0;
    int n_total = 0;

    bit obs_valid, obs_accept, obs_bus_ready;
    int obs_dest, obs_addr, obs_data;

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NADDR; i++) begin
            m_mem[i] = i; m_owned[i] = 0; m_owner[i] = 0; m_sharers[i] = 0; m_wbp[i] = 0;
        end
        m_q.delete();
        cyc = 0;
    endtask

    task automatic model_bus(input bus_cmd_t c, input int s, input int a);
        int sb;
        sb = 1 << s;
        case (c)
            BUS_GETS: if (!m_owned[a]) begin
                m_q.push_back('{s, a, cyc});
                if (m_sharers[a] == 0) begin m_owned[a] = 1; m_owner[a] = s; end
                m_sharers[a] |= sb;
            end else begin
                m_sharers[a] |= sb | (1 << m_owner[a]);
                m_owned[a] = 0;
                m_wbp[a]   = 1;
            end
            BUS_GETM: begin
                if (!m_owned[a]) m_q.push_back('{s, a, cyc});
                m_owned[a] = 1; m_owner[a] = s; m_sharers[a] = sb;
            end
            BUS_PUTM: if (m_owned[a] && m_owner[a] == s) begin
                m_owned[a] = 0; m_sharers[a] &= ~sb; m_wbp[a] = 1;
            end
            default: ;
        endcase
    endtask

    // One clock cycle: compare settled outputs, then advance the model.
    task automatic step();
        bit ev, wbh, acc;
        int ed;
        #1;
        wbh = wb_in.valid && wb_in.writeback;
        ev  = (m_q.size() > 0) && (cyc >= m_q[0].t + LAT) && !m_wbp[m_q[0].addr];
        check("bus_ready", bus_ready, m_q.size() < DEPTH);
        check("resp_valid", resp_out.valid, ev);
        if (ev) begin
            ed = (wbh && wb_in.addr == m_q[0].addr) ? int'(wb_in.data) : m_mem[m_q[0].addr];
            check("resp_dest", resp_out.dest, m_q[0].dest);
            check("resp_addr", resp_out.addr, m_q[0].addr);
            check("resp_data", resp_out.data, ed);
            check("resp_wb", resp_out.writeback, 0);
        end
        obs_valid = resp_out.valid; obs_dest = resp_out.dest;
        obs_addr = resp_out.addr;   obs_data = resp_out.data;
        obs_bus_ready = bus_ready;
        acc = bus_in.valid && (m_q.size() < DEPTH) && (bus_in.cmd != BUS_IDLE);
        if (ev && resp_ready) void'(m_q.pop_front());
        if (wbh) begin m_mem[wb_in.addr] = wb_in.data; m_wbp[wb_in.addr] = 0; end
        if (acc) model_bus(bus_in.cmd, bus_in.source, bus_in.addr);
        obs_accept = acc;
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_bus(input bus_cmd_t c, input int s, input int a);
        bus_in.valid = 1'b1; bus_in.cmd = c;
        bus_in.source = CPU_W'(s); bus_in.addr = XLEN'(a);
    endtask

    // Holds a message on the bus until accepted; returns the accept cycle.
    task automatic send(input bus_cmd_t c, input int s, input int a, output int t_acc);
        bit done = 0;
        set_bus(c, s, a);
        for (int k = 0; k < 50 && !done; k++) begin
            step();
            done = obs_accept;
        end
        if (!done) check("send_timeout", 0, 1);
        t_acc = cyc - 1;
        bus_in = '0;
    endtask

    initial begin
        int t, tp, first_v, first_d, nval, wb_seen, nresp;
        int got_addr [$];
        bit fifth_in;

        rst = 1'b1; bus_in = '0; wb_in = '0; resp_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_resp_valid", resp_out.valid, 0);
        check("rst_resp_data", resp_out.data, 0);
        check("rst_bus_ready", bus_ready, 1);
        rst = 1'b0;

        // GetS 0x05 from CPU1: response exactly LAT cycles later with reset data.
        send(BUS_GETS, 1, 6'h05, t);
        first_v = -1; first_d = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_valid && first_v < 0) begin first_v = cyc - 1; first_d = obs_data; check("t1_dest", obs_dest, 1); end
        end
        check("t1_latency", first_v - t, LAT);
        check("t1_data", first_d, 8'h05);

        // CPU2 GetM while CPU1 owns: cache-to-cache, memory stays silent.
        send(BUS_GETM, 2, 6'h05, t);
        nval = 0;
        for (int k = 0; k < 8; k++) begin step(); nval += obs_valid; end
        check("t2_no_resp", nval, 0);

        // CPU2 PutM, CPU0 GetS: response waits for writeback A7 ten cycles later.
        send(BUS_PUTM, 2, 6'h05, tp);
        send(BUS_GETS, 0, 6'h05, t);
        nval = 0; wb_seen = 0; first_d = -1;
        for (int k = 0; k < 20; k++) begin
            if (cyc == tp + 10) wb_in = '{valid: 1'b1, dest: 2'd0, addr: 6'h05, data: 8'hA7, writeback: 1'b1};
            else wb_in = '0;
            step();
            if (obs_valid && !wb_seen) nval++;
            if (obs_valid && first_d < 0) first_d = obs_data;
            if (cyc - 1 == tp + 10) wb_seen = 1;
        end
        wb_in = '0;
        check("t3_stall", nval, 0);
        check("t3_data", first_d, 8'hA7);

        // Five GetS with resp_ready low: fills after four, drains in order.
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(BUS_GETS, i, 6'h20 + i, t);
        set_bus(BUS_GETS, 0, 6'h24);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_full_ready", obs_bus_ready, 0);
            check("t4_held", obs_accept, 0);
        end
        resp_ready = 1'b1;
        fifth_in = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (obs_accept) begin fifth_in = 1; bus_in = '0; end
            if (obs_valid) got_addr.push_back(obs_addr);
        end
        check("t4_fifth_accepted", fifth_in, 1);
        check("t4_count", got_addr.size(), 5);
        nresp = got_addr.size();
        for (int i = 0; i < nresp && i < 5; i++) check("t4_order", got_addr[i], 6'h20 + i);

        // Stale PutM from CPU3 is ignored; memory still answers a later GetS.
        send(BUS_PUTM, 3, 6'h10, t);
        repeat (2) step();
        send(BUS_GETS, 0, 6'h10, t);
        first_d = -1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_valid && first_d < 0) begin first_d = obs_data; check("t5_dest", obs_dest, 0); end
        end
        check("t5_data", first_d, 8'h10);

        // Reset with three responses queued and eligible.
        resp_ready = 1'b0;
        send(BUS_GETS, 1, 6'h30, t);
        send(BUS_GETS, 2, 6'h31, t);
        send(BUS_GETS, 3, 6'h32, t);
        repeat (5) step();
        check("t6_pre_valid", obs_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", resp_out.valid, 0);
        check("t6_rst_ready", bus_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        repeat (6) step();
        send(BUS_GETS, 1, 6'h05, t);
        first_d = -1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_valid && first_d < 0) first_d = obs_data;
        end
        check("t6_post_data", first_d, 8'h05);

        // Random traffic over a small address window to force collisions.
        for (int k = 0; k < 1500; k++) begin
            bus_in.valid  = ($urandom_range(0, 9) < 7);
            bus_in.cmd    = bus_cmd_t'($urandom_range(0, 3));
            bus_in.source = CPU_W'($urandom_range(0, NUM_CPUS - 1));
            bus_in.addr   = XLEN'($urandom_range(0, 7));
            wb_in.valid     = ($urandom_range(0, 3) == 0);
            wb_in.writeback = ($urandom_range(0, 4) != 0);
            wb_in.dest      = CPU_W'($urandom_range(0, NUM_CPUS - 1));
            wb_in.addr      = XLEN'($urandom_range(0, 7));
            wb_in.data      = DLEN'($urandom_range(0, 255));
            resp_ready      = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
